uart_rx: RTL and testbench

//  Bus-mapped UART receiver; serial counterpart of the uart_tx peripheral on the same 8-bit register bus.

---
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver with 4-entry byte FIFO on the 8-bit register bus.
// Define UART_RX_PARITY_EN for 8E1 frames with a live perr flag; default is 8N1.
module uart_rx #(
    parameter logic [7:0] PERIOD = 8'h1A,
    parameter int         DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wren,
    input  logic       rden,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxin,
    input  logic [2:0] addr,
    output logic       rxirq
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t state, state_n;

    logic          rs1, rxs, rxd;
    logic [7:0]    div, dv, cnt, shreg;
    logic [2:0]    idx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          ovr, ferr, perr;
    logic          avail, full, busy, fall;
    logic          t_half, t_full, cnt_clr;
    logic          shift, push_req, push_ok, pop;
    logic          ferr_set, ovr_set, perr_set;
    logic          wr1, wr2;
    logic [2:0]    clr;
    logic [7:0]    status, rdata;

    // divisors below 2 would never let the half-bit point differ from zero
    assign dv      = (div < 8'd2) ? 8'd2 : div;
    assign t_half  = cnt == (dv >> 1);
    assign t_full  = cnt == dv - 8'd1;
    assign fall    = rxd & ~rxs;
    assign busy    = state != IDLE;
    assign cnt_clr = (state == IDLE) || (state_n != state) || shift;

    assign avail = count != '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign rxirq = avail;

    assign pop     = rden && addr == 3'd0 && avail;
    assign push_ok = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    assign wr1 = wren && addr == 3'd1;
    assign wr2 = wren && addr == 3'd2 && !busy;
    assign clr = wr1 ? din[4:2] : 3'b000;

    assign status = {2'b00, busy, perr, ovr, ferr, full, avail};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1 <= 1'b1;
            rxs <= 1'b1;
            rxd <= 1'b1;
        end else begin
            rs1 <= rxin;
            rxs <= rs1;
            rxd <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (fall) state_n = START;
            START: if (t_half) state_n = rxs ? IDLE : DATA;
            DATA:
                if (t_full && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PAR;
`else
                    state_n = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
            PAR:   if (t_full) state_n = STOP;
`endif
            STOP:  if (t_full) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        shift    = 1'b0;
        push_req = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        unique case (state)
            DATA: shift = t_full;
            STOP: begin
                push_req = t_full && rxs;
                ferr_set = t_full && !rxs;
            end
`ifdef UART_RX_PARITY_EN
            PAR:  perr_set = t_full && (rxs != ^shreg);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            cnt <= cnt_clr ? 8'd0 : cnt + 8'd1;
            if (state == START) idx <= '0;
            else if (shift)     idx <= idx + 3'd1;
            if (shift) shreg[idx] <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // hardware set dominates a same-cycle software clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
            div  <= PERIOD;
        end else begin
            ferr <= (ferr & ~clr[0]) | ferr_set;
            ovr  <= (ovr & ~clr[1]) | ovr_set;
            if (wr2) div <= din;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr <= 1'b0;
        else       perr <= (perr & ~clr[2]) | perr_set;
    end
`else
    assign perr = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            addr == 3'd0: rdata = avail ? mem[rptr] : 8'h00;
            addr == 3'd1: rdata = status;
            addr == 3'd2: rdata = div;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     dout <= '0;
        else if (rden) dout <= rdata;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model (byte queue + sticky flags)
// compared against rxirq every cycle and against dout on every register read.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wren = 1'b0;
    logic       rden = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] addr = 3'd0;
    logic       rxin = 1'b1;
    logic [7:0] dout;
    logic       rxirq;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk   (clk),
        .reset (reset),
        .wren  (wren),
        .rden  (rden),
        .din   (din),
        .dout  (dout),
        .rxin  (rxin),
        .addr  (addr),
        .rxirq (rxirq)
    );

    logic [7:0] mq[$];
    bit         m_ovr = 0, m_ferr = 0, m_perr = 0;
    logic [7:0] m_div = 8'h1A;

    int         n_pass = 0, n_tot = 0;
    bit         irq_chk = 0, rd_pend = 0, lit_pend = 0;
    logic [7:0] rd_exp = 8'h00, lit_exp = 8'h00;
    string      rd_name = "none";

    function automatic logic [7:0] m_status();
        return {2'b00, 1'b0, m_perr, m_ovr, m_ferr,
                mq.size() == 4, mq.size() != 0};
    endfunction

    always @(negedge clk) begin
        if (irq_chk) begin
            n_tot++;
            if (rxirq === (mq.size() != 0)) n_pass++;
            else $display("FAIL rxirq: got %0b expected %0b at %0t",
                          rxirq, mq.size() != 0, $time);
        end
        if (rd_pend) begin
            n_tot++;
            if (dout === rd_exp) n_pass++;
            else $display("FAIL %s model: dout=%02h expected %02h",
                          rd_name, dout, rd_exp);
        end
        if (lit_pend) begin
            n_tot++;
            if (dout === lit_exp) n_pass++;
            else $display("FAIL %s literal: dout=%02h expected %02h",
                          rd_name, dout, lit_exp);
        end
    end

    task automatic rd(input logic [2:0] a, input bit lit,
                      input logic [7:0] lv, input string nm);
        @(negedge clk); #1;
        addr = a;
        rden = 1'b1;
        case (a)
            3'd0:    rd_exp = (mq.size() != 0) ? mq[0] : 8'h00;
            3'd1:    rd_exp = m_status();
            3'd2:    rd_exp = m_div;
            default: rd_exp = 8'h00;
        endcase
        rd_name  = nm;
        lit_exp  = lv;
        lit_pend = lit;
        rd_pend  = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        if (a == 3'd0 && mq.size() != 0) void'(mq.pop_front());
        @(negedge clk); #1;
        rd_pend  = 1'b0;
        lit_pend = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        addr = a;
        din  = d;
        wren = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0;
        if (a == 3'd1) begin
            if (d[2]) m_ferr = 0;
            if (d[3]) m_ovr = 0;
            if (d[4]) m_perr = 0;
        end
        if (a == 3'd2) m_div = d;
    endtask

    task automatic hold(input logic v, input int n);
        rxin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit stopv, input bit pflip);
        int bt;
        bt = (m_div < 8'd2) ? 2 : int'(m_div);
        irq_chk = 0;
        @(negedge clk);
        hold(1'b0, bt);
        for (int i = 0; i < 8; i++) hold(b[i], bt);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ pflip, bt);
        if (pflip) m_perr = 1;
`endif
        hold(stopv, bt);
        hold(1'b1, 3);
        if (!stopv)              m_ferr = 1;
        else if (mq.size() < 4)  mq.push_back(b);
        else                     m_ovr = 1;
        irq_chk = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rxin  = 1'b1;
        mq.delete();
        m_ovr  = 0;
        m_ferr = 0;
        m_perr = 0;
        m_div  = 8'h1A;
        repeat (3) @(negedge clk);
        #1 lit_exp = 8'h00;
        rd_name  = "rst_dout";
        lit_pend = 1'b1;
        @(negedge clk); #1;
        lit_pend = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        irq_chk = 1;
        rd(3'd1, 1, 8'h00, "rst_status");
        rd(3'd2, 1, 8'h1A, "rst_div");
        rd(3'd0, 1, 8'h00, "rst_empty");

        send(8'h55, 1, 0);
        rd(3'd1, 1, 8'h01, "t1_status");
        rd(3'd0, 1, 8'h55, "t1_data");
        rd(3'd1, 1, 8'h00, "t1_drained");

        for (int i = 1; i <= 5; i++) send(8'(i), 1, 0);
        rd(3'd1, 1, 8'h0B, "t2_status");
        for (int i = 1; i <= 4; i++) rd(3'd0, 1, 8'(i), "t2_data");
        rd(3'd0, 1, 8'h00, "t2_empty");
        rd(3'd1, 1, 8'h08, "t2_ovr_sticky");
        wr(3'd1, 8'h08);
        rd(3'd1, 1, 8'h00, "t2_ovr_clr");

        send(8'hA3, 0, 0);
        rd(3'd1, 1, 8'h04, "t3_ferr");
        wr(3'd1, 8'h04);
        rd(3'd1, 1, 8'h00, "t3_ferr_clr");

        irq_chk = 0;
        @(negedge clk);
        hold(1'b0, 10);
        hold(1'b1, 40);
        irq_chk = 1;
        rd(3'd1, 1, 8'h00, "t4_false_start");

        rd(3'd5, 1, 8'h00, "unmapped_rd");
        wr(3'd5, 8'hFF);
        rd(3'd1, 1, 8'h00, "unmapped_wr");
        wr(3'd2, 8'h01);
        rd(3'd2, 1, 8'h01, "div_small");

        wr(3'd2, 8'h10);
        rd(3'd2, 1, 8'h10, "t5_div");
        send(8'h3C, 1, 0);
        rd(3'd0, 1, 8'h3C, "t5_data");

        irq_chk = 0;
        @(negedge clk);
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 20);
        do_reset();
        irq_chk = 1;
        rd(3'd1, 1, 8'h00, "t5_rst_status");
        rd(3'd2, 1, 8'h1A, "t5_rst_div");
        send(8'h96, 1, 0);
        rd(3'd0, 1, 8'h96, "t5_clean");
        rd(3'd1, 1, 8'h00, "t5_clean_status");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 1);
        rd(3'd1, 1, 8'h11, "t6_perr");
        rd(3'd0, 1, 8'h07, "t6_data");
        wr(3'd1, 8'h10);
        rd(3'd1, 1, 8'h00, "t6_perr_clr");
`endif

        irq_chk = 0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
